// File: rtl/bch_encode_par_pkg.sv
// Shared definitions for the parallel systematic BCH encoder: FSM states and
// the default generator polynomial of the (63,24) code.
package bch_encode_par_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MSG  = 2'd1,
        PAR  = 2'd2
    } state_e;

    localparam logic [39:0] GPOLY_DEFAULT = 40'hF69AC20921;

endpackage

// File: rtl/bch_encode_par_lfsr_step.sv
// Combinational P-step advance of the systematic-encoder remainder register;
// data_i bit P-1 is consumed first.
module bch_lfsr_step
    import bch_encode_par_pkg::*;
#(
    parameter int           R     = 39,
    parameter int           P     = 3,
    parameter logic [R:0]   GPOLY = (R+1)'(GPOLY_DEFAULT)
) (
    input  logic [R-1:0] rem_i,
    input  logic [P-1:0] data_i,
    output logic [R-1:0] rem_o
);

    // Unrolled division steps: feedback is the outgoing remainder MSB xor the message bit
    always_comb begin : p_step
        logic [R-1:0] r;
        logic         fb;
        r  = rem_i;
        fb = 1'b0;
        for (int i = P - 1; i >= 0; i--) begin
            fb = r[R-1] ^ data_i[i];
            r  = {r[R-2:0], 1'b0} ^ (GPOLY[R-1:0] & {R{fb}});
        end
        rem_o = r;
    end

endmodule

// File: rtl/bch_encode_par.sv
// Parallel systematic BCH encoder: P message bits per beat pass straight through,
// then (N-K)/P parity beats are shifted out of the remainder, MSB first.
module bch_encode_par
    import bch_encode_par_pkg::*;
#(
    parameter int               N     = 63,
    parameter int               K     = 24,
    parameter int               P     = 3,
    parameter logic [N-K:0]     GPOLY = (N-K+1)'(GPOLY_DEFAULT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [P-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         s_last,
    output logic [P-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         m_last,
    output logic         m_parity,
    output logic         err_len
);

    localparam int R  = N - K;
    localparam int KB = K / P;
    localparam int PB = R / P;
    localparam int CW = $clog2(KB + 1);
    localparam int PW = $clog2(PB + 1);

    if (((K % P) != 0) || ((R % P) != 0)) begin : g_bad_p
        $error("bch_encode_par: P must divide both K and N-K");
    end
    if ((GPOLY[0] != 1'b1) || (GPOLY[R] != 1'b1)) begin : g_bad_poly
        $error("bch_encode_par: GPOLY must have x^0 and x^(N-K) terms");
    end

    state_e         state_q, state_d;
    logic [R-1:0]   rem_q, rem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  pcnt_q, pcnt_d;
    logic [P-1:0]   m_data_q, m_data_d;
    logic           m_valid_q, m_valid_d;
    logic           m_last_q, m_last_d;
    logic           m_parity_q, m_parity_d;
    logic           err_q, err_d;

    logic [R-1:0]   rem_base_s;
    logic [R-1:0]   rem_step_s;
    logic           out_free_s;
    logic           s_fire_s;
    logic           at_limit_s;

    assign out_free_s = !m_valid_q || m_ready;
    assign s_ready    = !rst && (state_q != PAR) && out_free_s;
    assign s_fire_s   = s_valid && s_ready;
    // cnt_q is always 0 in IDLE, so this also covers the one-beat-frame case
    assign at_limit_s = (cnt_q == CW'(KB - 1));
    assign rem_base_s = (state_q == IDLE) ? '0 : rem_q;

    bch_lfsr_step #(
        .R     (R),
        .P     (P),
        .GPOLY (GPOLY)
    ) u_step (
        .rem_i  (rem_base_s),
        .data_i (s_data),
        .rem_o  (rem_step_s)
    );

    // Next-state, remainder and output-register logic
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        pcnt_d     = pcnt_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q  && !m_ready;
        m_last_d   = m_last_q   && !m_ready;
        m_parity_d = m_parity_q && !m_ready;
        err_d      = err_q;
        case (state_q)
            IDLE, MSG: begin
                if (s_fire_s) begin
                    rem_d      = rem_step_s;
                    m_data_d   = s_data;
                    m_valid_d  = 1'b1;
                    m_last_d   = 1'b0;
                    m_parity_d = 1'b0;
                    if (s_last || at_limit_s) begin
                        state_d = PAR;
                        cnt_d   = '0;
                        pcnt_d  = '0;
                        if (!s_last) begin
                            err_d = 1'b1;
                        end else begin
                            err_d = err_q;
                        end
                    end else begin
                        state_d = MSG;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            PAR: begin
                if (pcnt_q != PW'(PB)) begin
                    if (out_free_s) begin
                        m_data_d   = rem_q[R-1 -: P];
                        rem_d      = rem_q << P;
                        m_valid_d  = 1'b1;
                        m_parity_d = 1'b1;
                        m_last_d   = (pcnt_q == PW'(PB - 1));
                        pcnt_d     = pcnt_q + PW'(1);
                    end else begin
                        pcnt_d = pcnt_q;
                    end
                end else if (m_ready) begin
                    // final parity beat leaves this cycle
                    state_d = IDLE;
                    pcnt_d  = '0;
                    rem_d   = '0;
                end else begin
                    state_d = PAR;
                end
            end
            default: begin
                state_d   = IDLE;
                rem_d     = '0;
                cnt_d     = '0;
                pcnt_d    = '0;
                m_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            cnt_q      <= '0;
            pcnt_q     <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_parity_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            pcnt_q     <= pcnt_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            m_parity_q <= m_parity_d;
            err_q      <= err_d;
        end
    end

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign m_parity = m_parity_q;
    assign err_len  = err_q;

endmodule

// File: tb/tb_bch_encode_par.sv
// Self-checking bench for bch_encode_par: random frames and backpressure against
// a polynomial long-division reference model.
module tb_bch_encode_par;

    localparam int N  = 63;
    localparam int K  = 24;
    localparam int P  = 3;
    localparam int R  = 39;
    localparam int PB = 13;
    localparam logic [39:0] G = 40'hF69AC20921;
    localparam logic [38:0] PAR_ONE = 39'h769AC20921;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [P-1:0] s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_last = 1'b0;
    logic         s_ready;
    logic [P-1:0] m_data;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic         m_last;
    logic         m_parity;
    logic         err_len;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [P-1:0] data;
        logic         last;
        logic         par;
    } beat_t;

    beat_t outq[$];
    bit    rand_rdy = 1'b0;
    bit    rand_stall = 1'b0;
    beat_t held;
    bit    held_v = 1'b0;

    bch_encode_par dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_last   (s_last),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .m_parity (m_parity),
        .err_len  (err_len)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #2;
        m_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Output monitor: collect transfers and check that a stalled beat holds
    always @(negedge clk) begin
        if (held_v) begin
            tests++;
            if (!(m_valid === 1'b1 && m_data === held.data && m_last === held.last
                  && m_parity === held.par)) begin
                fails++;
                $display("FAIL stall_hold: got v=%b d=%h l=%b p=%b required v=1 d=%h l=%b p=%b",
                         m_valid, m_data, m_last, m_parity, held.data, held.last, held.par);
            end
        end
        held_v = m_valid && !m_ready && !rst;
        held   = '{m_data, m_last, m_parity};
        if (m_valid && m_ready && !rst) outq.push_back('{m_data, m_last, m_parity});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: remainder of m(x)*x^(N-K) divided by g(x), by long division
    function automatic logic [R-1:0] model_par(input logic [K-1:0] msg);
        logic [N-1:0] v;
        logic [N-1:0] g;
        v = {msg, {R{1'b0}}};
        g = N'(G);
        for (int i = N - 1; i >= R; i--) begin
            if (v[i]) v = v ^ (g << (i - R));
        end
        return v[R-1:0];
    endfunction

    task automatic drive_frame(input logic [K-1:0] msg, input int L, input bit with_last,
                               output bit ok);
        ok = 1'b1;
        for (int b = 0; b < L; b++) begin
            int guard;
            while (rand_stall && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                @(posedge clk);
                #2;
            end
            s_data  = msg[(L-1-b)*P +: P];
            s_last  = with_last && (b == L - 1);
            s_valid = 1'b1;
            guard   = 0;
            @(negedge clk);
            while (!s_ready && guard < 200) begin
                guard++;
                @(negedge clk);
            end
            if (!s_ready) ok = 1'b0;
            @(posedge clk);
            #2;
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [K-1:0] msg, input int L, input bit with_last,
                             output bit ok, output int n, output logic [K-1:0] got_msg,
                             output logic [R-1:0] got_par, output logic [31:0] lastm,
                             output logic [31:0] parm);
        int guard;
        outq.delete();
        drive_frame(msg, L, with_last, ok);
        guard = 0;
        while (outq.size() < L + PB && guard < 500) begin
            guard++;
            @(negedge clk);
        end
        if (outq.size() < L + PB) ok = 1'b0;
        @(posedge clk);
        #2;
        n = outq.size();
        got_msg = '0;
        got_par = '0;
        lastm = '0;
        parm = '0;
        for (int i = 0; i < n && i < 32; i++) begin
            if (i < L) got_msg = {got_msg[K-P-1:0], outq[i].data};
            else       got_par = {got_par[R-P-1:0], outq[i].data};
            lastm[i] = outq[i].last;
            parm[i]  = outq[i].par;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL rst_s_ready: got %b required 0", s_ready); end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rst_m_valid: got %b required 0", m_valid); end
        tests++; if ({m_last, m_parity, m_data} !== 5'b0) begin fails++; $display("FAIL rst_m_out: got %b required 0", {m_last, m_parity, m_data}); end
        tests++; if (err_len !== 1'b0) begin fails++; $display("FAIL rst_err_len: got %b required 0", err_len); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic test_zero_msg();
        bit ok; int n; logic [K-1:0] gm; logic [R-1:0] gp; logic [31:0] lm, pm;
        rand_rdy = 1'b0; rand_stall = 1'b0;
        run_frame('0, 8, 1'b1, ok, n, gm, gp, lm, pm);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL zero_timeout: got %b required 1", ok); end
        tests++; if (n != 21) begin fails++; $display("FAIL zero_count: got %0d required 21", n); end
        tests++; if (gp !== '0) begin fails++; $display("FAIL zero_parity: got %h required 0", gp); end
        tests++; if (lm !== 32'h0010_0000) begin fails++; $display("FAIL zero_last: got %h required 00100000", lm); end
        tests++; if (pm !== 32'h001F_FF00) begin fails++; $display("FAIL zero_parflag: got %h required 001fff00", pm); end
    endtask

    task automatic test_single_one();
        bit ok; int n; logic [K-1:0] gm; logic [R-1:0] gp; logic [31:0] lm, pm;
        run_frame(24'h000001, 8, 1'b1, ok, n, gm, gp, lm, pm);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL one_timeout: got %b required 1", ok); end
        tests++; if (gm !== 24'h000001) begin fails++; $display("FAIL one_msg: got %h required 000001", gm); end
        tests++; if (gp !== PAR_ONE) begin fails++; $display("FAIL one_parity: got %h required %h", gp, PAR_ONE); end
    endtask

    task automatic test_shortened();
        bit ok; int n; logic [K-1:0] gm; logic [R-1:0] gp; logic [31:0] lm, pm;
        run_frame(24'h000001, 2, 1'b1, ok, n, gm, gp, lm, pm);
        tests++; if (n != 15) begin fails++; $display("FAIL short_count: got %0d required 15", n); end
        tests++; if (gp !== PAR_ONE) begin fails++; $display("FAIL short_parity: got %h required %h", gp, PAR_ONE); end
        tests++; if (lm !== 32'h0000_4000) begin fails++; $display("FAIL short_last: got %h required 00004000", lm); end
        tests++; if (err_len !== 1'b0) begin fails++; $display("FAIL short_err_len: got %b required 0", err_len); end
    endtask

    task automatic test_random();
        bit ok; int n; int L; logic [K-1:0] msg, gm; logic [R-1:0] gp, ep; logic [31:0] lm, pm;
        rand_rdy = 1'b1; rand_stall = 1'b1;
        for (int f = 0; f < 25; f++) begin
            L   = $urandom_range(1, 8);
            msg = K'($urandom) & ((K'(1) << (L * P)) - K'(1));
            ep  = model_par(msg);
            run_frame(msg, L, 1'b1, ok, n, gm, gp, lm, pm);
            tests++; if (ok !== 1'b1 || n != L + PB) begin fails++; $display("FAIL rand_count[%0d]: got ok=%b n=%0d required n=%0d", f, ok, n, L + PB); end
            tests++; if (gm !== msg) begin fails++; $display("FAIL rand_msg[%0d]: got %h required %h", f, gm, msg); end
            tests++; if (gp !== ep) begin fails++; $display("FAIL rand_parity[%0d]: got %h required %h", f, gp, ep); end
            tests++; if (lm !== (32'(1) << (L + PB - 1)) || pm !== (32'h1FFF << L)) begin
                fails++; $display("FAIL rand_flags[%0d]: got last=%h par=%h required last=%h par=%h",
                                  f, lm, pm, 32'(1) << (L + PB - 1), 32'h1FFF << L);
            end
        end
        tests++; if (err_len !== 1'b0) begin fails++; $display("FAIL rand_err_len: got %b required 0", err_len); end
        rand_rdy = 1'b0; rand_stall = 1'b0;
    endtask

    task automatic test_err_len();
        bit ok; int n; logic [K-1:0] msg, gm; logic [R-1:0] gp, ep; logic [31:0] lm, pm;
        msg = K'($urandom);
        ep  = model_par(msg);
        run_frame(msg, 8, 1'b0, ok, n, gm, gp, lm, pm);
        tests++; if (n != 21) begin fails++; $display("FAIL errlen_count: got %0d required 21", n); end
        tests++; if (gp !== ep) begin fails++; $display("FAIL errlen_parity: got %h required %h", gp, ep); end
        tests++; if (err_len !== 1'b1) begin fails++; $display("FAIL errlen_set: got %b required 1", err_len); end
        msg = K'($urandom) & 24'h007FFF;
        ep  = model_par(msg);
        run_frame(msg, 5, 1'b1, ok, n, gm, gp, lm, pm);
        tests++; if (gp !== ep || n != 18) begin fails++; $display("FAIL errlen_next: got %h n=%0d required %h n=18", gp, n, ep); end
        tests++; if (err_len !== 1'b1) begin fails++; $display("FAIL errlen_sticky: got %b required 1", err_len); end
    endtask

    task automatic test_reset_mid_parity();
        bit ok; int n; int np; int guard; int sz; logic [K-1:0] msg, gm; logic [R-1:0] gp, ep;
        logic [31:0] lm, pm;
        outq.delete();
        drive_frame(K'($urandom), 8, 1'b1, ok);
        guard = 0;
        np = 0;
        while (np < 4 && guard < 100) begin
            @(posedge clk);
            #2;
            guard++;
            np = 0;
            foreach (outq[i]) if (outq[i].par) np++;
        end
        tests++; if (np != 4) begin fails++; $display("FAIL rstpar_reach: got %0d parity beats required 4", np); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rstpar_m_valid: got %b required 0", m_valid); end
        tests++; if (err_len !== 1'b0) begin fails++; $display("FAIL rstpar_err_len: got %b required 0", err_len); end
        sz = outq.size();
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        tests++; if (outq.size() != sz || sz != 12) begin fails++; $display("FAIL rstpar_discard: got %0d beats required 12", outq.size()); end
        msg = K'($urandom);
        ep  = model_par(msg);
        run_frame(msg, 8, 1'b1, ok, n, gm, gp, lm, pm);
        tests++; if (gp !== ep || gm !== msg || n != 21) begin fails++; $display("FAIL rstpar_next: got %h/%h n=%0d required %h/%h n=21", gm, gp, n, msg, ep); end
    endtask

    initial begin
        test_reset();
        test_zero_msg();
        test_single_one();
        test_shortened();
        test_random();
        test_err_len();
        test_reset_mid_parity();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bch_encode_par.md
BCH_ENCODE_PAR -- requirements
Module: bch_encode_par

Interface
REQ-001 Parameter N, default 63: codeword length in bits.
REQ-002 Parameter K, default 24: message length in bits.
REQ-003 Parameter P, default 3: bits per beat; P SHALL divide both K and N-K (elaboration error otherwise).
REQ-004 Parameter GPOLY, default 40'hF69AC20921: generator polynomial, width N-K+1, bit i = coefficient of x^i, bits 0 and N-K SHALL be 1.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 s_data  in  P  message beat; bit P-1 is the earliest (highest-degree) bit.
REQ-008 s_valid  in  1  / s_ready  out  1: input handshake; a beat transfers when both are high.
REQ-009 s_last  in  1  marks the final message beat (shortened-code support).
REQ-010 m_data  out  P  codeword beat, same bit order as s_data.
REQ-011 m_valid  out  1  / m_ready  in  1: output handshake; a beat transfers when both are high.
REQ-012 m_last  out  1  high on the final parity beat of a codeword.
REQ-013 m_parity  out  1  high while m_data carries parity bits.
REQ-014 err_len  out  1  sticky: frame reached K/P beats without s_last; cleared only by rst.

Function
REQ-015 Encoding SHALL be systematic: c(x) = m(x)*x^(N-K) + (m(x)*x^(N-K) mod g(x)), message first, then parity MSB (r_{N-K-1}) first.
REQ-016 The remainder register (N-K bits) SHALL advance P bit-steps per accepted beat via an unrolled P-step LFSR update.
REQ-017 FSM states: IDLE, MSG, PAR.
REQ-018 IDLE: remainder = 0; s_ready high when output register free; first accepted beat enters MSG (or PAR if s_last or K/P = 1).
REQ-019 MSG: each accepted beat updates the remainder and is copied to the output register.
REQ-019a MSG: leave to PAR on the beat with s_last or on beat K/P.
REQ-020 A frame of L < K/P beats SHALL be encoded as a shortened code (implicit leading zeros); parity SHALL equal the full-length encoding of the zero-padded message.
REQ-021 Beat K/P without s_last SHALL end the frame anyway and set err_len; extra beats start a new frame.
REQ-022 PAR: s_ready low; emit (N-K)/P parity beats by shifting out the top P remainder bits per m transfer.
REQ-022a PAR: m_last on the final parity beat; return to IDLE when that beat transfers.
REQ-023 Output is a single registered stage: m_valid asserts the cycle after an input beat is accepted (latency 1).
REQ-024 s_ready = state != PAR and (!m_valid or m_ready), allowing full throughput of one beat per cycle with m_ready held high.
REQ-025 m_data/m_valid/m_last/m_parity SHALL hold stable while m_valid and !m_ready.
REQ-026 Input stall (s_valid low) mid-frame SHALL not alter remainder or beat count.
REQ-027 The transition PAR->IDLE and the next frame's first input beat may occur in the same cycle the last parity beat transfers (no bubble required, one permitted).

Reset
REQ-028 While rst is high at a clock edge: state = IDLE, remainder = 0, beat count = 0, m_valid = 0, m_last = 0, m_parity = 0, m_data = 0, err_len = 0.
REQ-029 s_ready SHALL be 0 during reset cycles.
REQ-030 Reset mid-frame SHALL discard the frame without emitting further beats.

Structure
REQ-031 A shared package SHALL hold the FSM state enum and the default GPOLY constant.
REQ-032 The P-step remainder update SHALL be a sub-module bch_lfsr_step (parameters N-K, P, GPOLY; purely combinational).

Verification
REQ-033 All-zero 24-bit message, 8 beats, m_ready=1 -> 21 output beats, 13 parity beats all zero, m_last on beat 21.
REQ-034 Message with only m_0=1 (last bit of beat 8) -> parity = 39'h769AC20921.
REQ-035 Random messages, random s_valid/m_ready backpressure -> codewords match software model; output stable under stall.
REQ-036 Shortened frame: 2 beats {3'b000, 3'b001} with s_last -> parity 39'h769AC20921; err_len stays 0.
REQ-037 8 beats without s_last -> frame closes at beat 8, err_len=1 and stays high; next frame encodes correctly.
REQ-038 rst asserted during parity beat 5 -> m_valid=0 next cycle; subsequent frame encodes correctly from remainder 0.
